// File: rtl/slip_axis_encoder_noid_pkg.sv
// Shared SLIP symbol defaults and escaper FSM encoding for the AXI-S SLIP encoder.
package slip_axis_encoder_noid_pkg;

  localparam int         DEF_SYMBOL_WIDTH   = 8;
  localparam logic [7:0] DEF_SYMBOL_END     = 8'hC0;
  localparam logic [7:0] DEF_SYMBOL_ESC     = 8'hDB;
  localparam logic [7:0] DEF_SYMBOL_ESC_END = 8'hDC;
  localparam logic [7:0] DEF_SYMBOL_ESC_ESC = 8'hDD;

  localparam logic [1:0] S_PASS = 2'd0;
  localparam logic [1:0] S_ESC2 = 2'd1;
  localparam logic [1:0] S_END  = 2'd2;
  localparam logic [1:0] S_LEAD = 2'd3;

endpackage

// File: rtl/slip_escaper.sv
// SLIP escaper: turns data/end requests into a single registered SLIP symbol slot.
// Handshake: a request is taken when i_valid && o_ready; the output symbol is
// transferred when o_valid && i_ready, and is held stable while o_valid && !i_ready.
module slip_escaper
  import slip_axis_encoder_noid_pkg::*;
#(
  parameter int                      SYMBOL_WIDTH   = DEF_SYMBOL_WIDTH,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_END     = DEF_SYMBOL_END,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_ESC     = DEF_SYMBOL_ESC,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_ESC_END = DEF_SYMBOL_ESC_END,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_ESC_ESC = DEF_SYMBOL_ESC_ESC
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  input  logic [SYMBOL_WIDTH-1:0] i_data,
  input  logic                    i_has_data,
  input  logic                    i_end,
  input  logic                    i_lead,
  output logic                    o_ready,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [SYMBOL_WIDTH-1:0] o_data,
  output logic [1:0]              o_state
);

  logic [1:0]              state_q, state_d;
  logic                    valid_q, valid_d;
  logic [SYMBOL_WIDTH-1:0] data_q, data_d;
  logic [SYMBOL_WIDTH-1:0] hold_q, hold_d;
  logic                    last_q, last_d;

  logic                    slot_free;
  logic                    do_process;
  logic [SYMBOL_WIDTH-1:0] proc_data;
  logic                    proc_last;

  // S_LEAD replays the beat captured while its leading END went out.
  assign proc_data = (state_q == S_LEAD) ? hold_q : i_data;
  assign proc_last = (state_q == S_LEAD) ? last_q : i_end;

  always_comb begin
    slot_free  = !valid_q || i_ready;
    o_ready    = (state_q == S_PASS) && slot_free && i_rst_n;
    state_d    = state_q;
    valid_d    = valid_q;
    data_d     = data_q;
    hold_d     = hold_q;
    last_d     = last_q;
    do_process = 1'b0;
    if (slot_free) valid_d = 1'b0;

    case (state_q)
      S_PASS: begin
        if (i_valid && o_ready) begin
          if (!i_has_data) begin
            if (i_end) begin
              valid_d = 1'b1;
              data_d  = SYMBOL_END;
            end
          end else if (i_lead) begin
            valid_d = 1'b1;
            data_d  = SYMBOL_END;
            hold_d  = i_data;
            last_d  = i_end;
            state_d = S_LEAD;
          end else begin
            do_process = 1'b1;
          end
        end
      end
      S_LEAD: do_process = slot_free;
      S_ESC2: begin
        if (slot_free) begin
          valid_d = 1'b1;
          data_d  = hold_q;
          state_d = last_q ? S_END : S_PASS;
        end
      end
      S_END: begin
        if (slot_free) begin
          valid_d = 1'b1;
          data_d  = SYMBOL_END;
          state_d = S_PASS;
        end
      end
    endcase

    if (do_process) begin
      valid_d = 1'b1;
      if (proc_data == SYMBOL_END || proc_data == SYMBOL_ESC) begin
        data_d  = SYMBOL_ESC;
        hold_d  = (proc_data == SYMBOL_END) ? SYMBOL_ESC_END : SYMBOL_ESC_ESC;
        last_d  = proc_last;
        state_d = S_ESC2;
      end else begin
        data_d  = proc_data;
        state_d = proc_last ? S_END : S_PASS;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_PASS;
      valid_q <= 1'b0;
      data_q  <= '0;
      hold_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_state = state_q;

endmodule

// File: rtl/slip_axis_encoder_noid.sv
// AXI-S (TKEEP/TLAST) to SLIP symbol stream encoder; optional leading END per packet.
module slip_axis_encoder_noid
  import slip_axis_encoder_noid_pkg::*;
#(
  parameter int                      SYMBOL_WIDTH   = DEF_SYMBOL_WIDTH,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_END     = DEF_SYMBOL_END,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_ESC     = DEF_SYMBOL_ESC,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_ESC_END = DEF_SYMBOL_ESC_END,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_ESC_ESC = DEF_SYMBOL_ESC_ESC,
  parameter bit                      LEAD_END       = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_s_axis_tvalid,
  output logic                    o_s_axis_tready,
  input  logic [SYMBOL_WIDTH-1:0] i_s_axis_tdata,
  input  logic                    i_s_axis_tkeep,
  input  logic                    i_s_axis_tlast,
  output logic                    o_m_axis_tvalid,
  input  logic                    i_m_axis_tready,
  output logic [SYMBOL_WIDTH-1:0] o_m_axis_tdata
);

  logic       in_pkt_q, in_pkt_d;
  logic       lead;
  logic       accept;
  logic [1:0] esc_state;

  assign lead   = LEAD_END && !in_pkt_q;
  assign accept = i_s_axis_tvalid && o_s_axis_tready;

  // The packet closes whenever the escaper sits in S_END or a bare END beat is taken.
  always_comb begin
    in_pkt_d = in_pkt_q;
    if (esc_state == S_END) begin
      in_pkt_d = 1'b0;
    end else if (accept) begin
      if (i_s_axis_tkeep)      in_pkt_d = 1'b1;
      else if (i_s_axis_tlast) in_pkt_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) in_pkt_q <= 1'b0;
    else          in_pkt_q <= in_pkt_d;
  end

  slip_escaper #(
    .SYMBOL_WIDTH  (SYMBOL_WIDTH),
    .SYMBOL_END    (SYMBOL_END),
    .SYMBOL_ESC    (SYMBOL_ESC),
    .SYMBOL_ESC_END(SYMBOL_ESC_END),
    .SYMBOL_ESC_ESC(SYMBOL_ESC_ESC)
  ) u_escaper (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_s_axis_tvalid),
    .i_data    (i_s_axis_tdata),
    .i_has_data(i_s_axis_tkeep),
    .i_end     (i_s_axis_tlast),
    .i_lead    (lead),
    .o_ready   (o_s_axis_tready),
    .i_ready   (i_m_axis_tready),
    .o_valid   (o_m_axis_tvalid),
    .o_data    (o_m_axis_tdata),
    .o_state   (esc_state)
  );

endmodule
